enc16_1_tra_select: RTL
=======================

# enc16_1_tra_select

Transmit-side bus selector for the 16 CAN buses. It is the counterpart of the receive-side bit-clearing decoder. It collects per-bus "message pending" flags into a 16-bit pending register. It then picks one bus at a time using round-robin priority and presents that bus as a 5-bit select to the transmit path. The bus's flag is cleared once the transmitter acknowledges it, or the bus is skipped after an acknowledge timeout.

## Interface
Parameters:
- `N_BUSES`, 16, number of buses; fixed at 16 for this revision.
- `SEL_W`, 5, select width; matches the receive-side select width.
- `TIMEOUT_CYC`, 255, number of GRANT cycles without `tra_ack` before the grant is abandoned (range 2..255).

Ports:
- `clk`, in, 1, single clock for the block.
- `rst`, in, 1, synchronous reset, active-high.
- `req_in`, in, 16, per-bus pending-message flags.
- `req_load`, in, 1, ORs `req_in` into the pending register this cycle.
- `tra_ack`, in, 1, transmitter has taken the currently selected bus; honoured only in GRANT.
- `bus_tra_select`, out, 5, selected bus index 0..15; reads 5'h1F when `sel_valid`=0.
- `sel_valid`, out, 1, `bus_tra_select` is valid and stable.
- `pending_out`, out, 16, current pending register.
- `timeout_err`, out, 1, one-cycle pulse when a grant is abandoned.

## Operation
- **Reset.** When `rst`=1 at a clock edge, the following are forced:
  - pending = 0
  - rr_ptr = 0
  - state = IDLE
  - `bus_tra_select` = 5'h1F
  - `sel_valid` = 0
  - `timeout_err` = 0
  - timeout counter = 0
- **Reset priority.** Reset has priority over every other input, including `req_load` and `tra_ack`, and aborts any grant in progress.
- **Pending register update.** Each cycle: pending_next = (pending & ~clr_mask) | (req_load ? req_in : 0).
  - clr_mask is one-hot at the selected bus only in the cycle that `tra_ack` is accepted.
  - A bit that is set and cleared in the same cycle ends up set.
- **Search.** The search runs combinationally on the registered pending value.
  - Winner = lowest index i with i ≥ rr_ptr and pending[i]=1.
  - If there is none, winner = lowest index i with pending[i]=1, wrapping through 0.
  - rr_ptr is 4 bits.
- **State machine.**
  - IDLE:
    - `sel_valid`=0 and `bus_tra_select`=5'h1F.
    - If pending≠0: latch the winner into `bus_tra_select` as {1'b0, idx}, clear the counter, and go to GRANT.
  - GRANT:
    - `sel_valid`=1 and `bus_tra_select` is held constant.
    - On `tra_ack`=1: clear pending[idx], set rr_ptr = idx+1 (15 wraps to 0), go to IDLE.
    - Otherwise, if the counter = TIMEOUT_CYC−1: pulse `timeout_err`, set rr_ptr = idx+1, keep pending[idx], go to IDLE.
    - Otherwise: increment the counter.
- **Ignored and held inputs.**
  - `tra_ack` in IDLE is ignored.
  - New `req_load` bits arriving during GRANT never change the current select.
- **Acknowledge vs timeout.** If `tra_ack` arrives in the same cycle the counter reaches its limit, the acknowledge wins and there is no `timeout_err`.

## Timing
- `req_load` at edge T makes `pending_out` change at T+1 and `sel_valid` rise at T+2 (IDLE, then GRANT).
- `tra_ack` accepted at edge T:
  - `sel_valid`=0 and the pending bit is cleared at T+1.
  - The next grant, if any, starts at T+2.
  - Minimum grant spacing is 2 cycles.
- For a timeout, `sel_valid` stays high for exactly TIMEOUT_CYC cycles. `timeout_err` is high during the cycle that `sel_valid` falls.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Reset values.** Apply reset, then release.
  - Expect `pending_out`=16'h0000, `bus_tra_select`=5'h1F, `sel_valid`=0, `timeout_err`=0.
  - Assert `tra_ack`=1 in IDLE: expect no change to any output.
- **Round-robin order.** `req_load` with `req_in`=16'h8421, then `tra_ack` 1 cycle after each `sel_valid` rise.
  - Expect selects 0, 5, 10, 15 in that order.
  - Expect `pending_out` to step 8421 → 8420 → 8400 → 8000 → 0000.
- **Fairness and wrap.** Pending = 16'h8001 with rr_ptr = 1 (after a grant of bus 0). Then reload bit 0.
  - Expect 15 selected before 0.
  - After the ack of 15, rr_ptr = 0 and 0 is selected next.
- **Timeout.** `TIMEOUT_CYC`=4, `req_in`=16'h0006, no ack.
  - Expect select 1 for exactly 4 cycles, then a `timeout_err` pulse.
  - Expect select 2 next, with `pending_out` still 16'h0006.
- **Simultaneous set and clear.** `tra_ack` for bus 3 in the same cycle as `req_load` with `req_in`=16'h0008.
  - Expect pending[3]=1 afterwards and bus 3 re-granted later.
  - Repeat with ack and timeout limit in the same cycle: expect the bit cleared and no `timeout_err`.
- **Reset mid-grant.** Assert `rst` while in GRANT on bus 7 with pending 16'h0080 and `req_load` active.
  - Expect pending = 0 and `sel_valid` = 0 on the next edge.
  - Expect no grant after release until a new `req_load`.

Source files
------------

// File: rtl/enc16_1_tra_select.sv
// enc16_1_tra_select
// Transmit-side bus selector for the 16 CAN buses. Per-bus "message pending"
// flags collect in a 16-bit register. One bus at a time is granted in
// round-robin order and presented on a 5-bit select to the transmit path.
// A granted bus is cleared when the transmitter acknowledges it. If no
// acknowledge arrives within TIMEOUT_CYC cycles, the bus is skipped and its
// pending flag is kept.
//
// Ports:
//   clk            - block clock
//   rst            - synchronous reset, active-high
//   req_in         - per-bus pending-message flags
//   req_load       - ORs req_in into the pending register this cycle
//   tra_ack        - transmitter has taken the selected bus (GRANT only)
//   bus_tra_select - selected bus index, 5'h1F when no selection is valid
//   sel_valid      - bus_tra_select is valid and stable
//   pending_out    - current pending register
//   timeout_err    - one-cycle pulse when a grant is abandoned
module enc16_1_tra_select #(
  parameter int unsigned N_BUSES     = 16,
  parameter int unsigned SEL_W       = 5,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BUSES-1:0] req_in,
  input  logic               req_load,
  input  logic               tra_ack,
  output logic [SEL_W-1:0]   bus_tra_select,
  output logic               sel_valid,
  output logic [N_BUSES-1:0] pending_out,
  output logic               timeout_err
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam logic [SEL_W-1:0] SEL_NONE  = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state;
  logic [N_BUSES-1:0] pending;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   tmo_cnt;

  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   win_hi;
  logic [IDX_W-1:0]   win_lo;
  logic [IDX_W-1:0]   win_idx;
  logic               win_hi_found;
  logic               win_lo_found;
  logic               ack_c;
  logic               expire_c;
  logic [N_BUSES-1:0] clr_mask;
  logic [N_BUSES-1:0] set_mask;

  // The bus index under grant is held in the low bits of the registered select.
  assign grant_idx = bus_tra_select[IDX_W-1:0];

  // Round-robin search on the registered pending value. The first pass looks
  // for the lowest index at or above rr_ptr. The second pass is the wrap
  // fallback: the lowest set index overall.
  always_comb begin
    win_hi       = '0;
    win_lo       = '0;
    win_hi_found = 1'b0;
    win_lo_found = 1'b0;
    for (int unsigned i = 0; i < N_BUSES; i++) begin
      if (pending[i] && !win_hi_found && (IDX_W'(i) >= rr_ptr)) begin
        win_hi       = IDX_W'(i);
        win_hi_found = 1'b1;
      end
      if (pending[i] && !win_lo_found) begin
        win_lo       = IDX_W'(i);
        win_lo_found = 1'b1;
      end
    end
    win_idx = win_hi_found ? win_hi : win_lo;
  end

  // Acknowledge wins over an expiring counter in the same cycle.
  always_comb begin
    ack_c    = (state == GRANT) && tra_ack;
    expire_c = (state == GRANT) && !tra_ack && (tmo_cnt == CNT_LIMIT);
    clr_mask = ack_c ? (N_BUSES'(1) << grant_idx) : '0;
    set_mask = req_load ? req_in : '0;
  end

  // Pending register, grant state machine and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending        <= '0;
      rr_ptr         <= '0;
      state          <= IDLE;
      bus_tra_select <= SEL_NONE;
      sel_valid      <= 1'b0;
      timeout_err    <= 1'b0;
      tmo_cnt        <= '0;
    end else begin
      // A load that sets the bit being cleared leaves it set.
      pending     <= (pending & ~clr_mask) | set_mask;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|pending) begin
            bus_tra_select <= SEL_W'(win_idx);
            sel_valid      <= 1'b1;
            tmo_cnt        <= '0;
            state          <= GRANT;
          end else begin
            bus_tra_select <= SEL_NONE;
            sel_valid      <= 1'b0;
          end
        end
        GRANT: begin
          if (ack_c || expire_c) begin
            rr_ptr         <= grant_idx + IDX_W'(1);
            bus_tra_select <= SEL_NONE;
            sel_valid      <= 1'b0;
            timeout_err    <= expire_c;
            state          <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: begin
          bus_tra_select <= SEL_NONE;
          sel_valid      <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

  assign pending_out = pending;

  // Output invariants.
  a_sel_idle: assert property (@(posedge clk) disable iff (rst)
    !sel_valid |-> (bus_tra_select == SEL_NONE));
  a_sel_range: assert property (@(posedge clk) disable iff (rst)
    sel_valid |-> (bus_tra_select[SEL_W-1] == 1'b0));
  a_terr_idle: assert property (@(posedge clk) disable iff (rst)
    timeout_err |-> !sel_valid);

endmodule
